// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Ports:
//   clk, reset_n              write-domain clock, asynchronous active-low reset
//   enable_i                  gates new grants only; a running burst always completes
//   req_valid_i/req_data_i    per-requester valid and packed data (slice i at i*DATA_WIDTH)
//   req_ready_o               per-requester ready (combinational from grant and full)
//   fifo_full_i               FIFO full flag
//   fifo_wr_o/fifo_data_o     FIFO write enable and data
//   grant_o                   registered one-hot grant
//   busy_o                    high while a grant is active
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_nx;
    logic [NUM_REQ-1:0]   grant_nx;
    logic [IW-1:0]        last_grant, last_nx, win_idx;
    logic [BW-1:0]        beat_cnt, cnt_nx;
    logic                 xfer, granted_valid;
    int                   scan;

    assign busy_o        = (state == GRANT);
    assign req_ready_o   = grant_o & {NUM_REQ{busy_o & ~fifo_full_i}};
    assign xfer          = |(req_valid_i & req_ready_o);
    assign fifo_wr_o     = xfer;
    assign granted_valid = |(req_valid_i & grant_o);

    // grant_o is one-hot or zero, so OR-ing the masked slices selects the granted data (zero when idle)
    always_comb begin
        fifo_data_o = '0;
        for (int i = 0; i < NUM_REQ; i++)
            fifo_data_o = fifo_data_o | (req_data_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_o[i]}});
    end

    // scan starts just after the previous winner so that winner ends up with lowest priority
    always_comb begin
        win_idx = last_grant;
        scan    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan = (int'(last_grant) + k) % NUM_REQ;
            if (req_valid_i[scan])
                win_idx = IW'(scan);
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant_o;
        last_nx  = last_grant;
        cnt_nx   = beat_cnt;
        if (state == IDLE) begin
            if (enable_i && |req_valid_i) begin
                state_nx = GRANT;
                grant_nx = NUM_REQ'(1) << win_idx;
                last_nx  = win_idx;
                cnt_nx   = '0;
            end
        end else if (xfer && beat_cnt == BW'(MAX_BURST - 1)) begin
            state_nx = IDLE;
            grant_nx = '0;
        end else if (xfer) begin
            cnt_nx = beat_cnt + 1'b1;
        end else if (!granted_valid) begin
            state_nx = IDLE;
            grant_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_o    <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nx;
            grant_o    <= grant_nx;
            last_grant <= last_nx;
            beat_cnt   <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4).
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable_i = 1'b1;
    logic             fifo_full_i = 1'b0;
    logic [N-1:0]     req_valid_i = '0;
    logic [N*W-1:0]   req_data_i = '0;
    logic [N-1:0]     req_ready_o;
    logic             fifo_wr_o;
    logic [W-1:0]     fifo_data_o;
    logic [N-1:0]     grant_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;
    int rem [N];
    logic [W-1:0] nxt [N];
    logic full_v = 1'b0;
    logic en_v = 1'b1;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .fifo_full_i(fifo_full_i), .fifo_wr_o(fifo_wr_o), .fifo_data_o(fifo_data_o),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    function automatic logic [W-1:0] word(input int g, input int b);
        return W'((g + 1) << 28) + W'(32'h100) + W'(b);
    endfunction

    task automatic drive();
        fifo_full_i = full_v;
        enable_i    = en_v;
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]       = rem[i] > 0;
            req_data_i[i*W +: W] = nxt[i];
        end
    endtask

    // Ends the current cycle: records transfers, crosses the edge, retires accepted words, settles new inputs.
    task automatic cyc();
        logic [N-1:0] xm;
        xm = req_valid_i & req_ready_o;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++)
            if (xm[i]) begin rem[i]--; nxt[i]++; end
        drive(); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; full_v = 1'b0; en_v = 1'b1;
        for (int i = 0; i < N; i++) begin rem[i] = 0; nxt[i] = word(i, 0); end
        drive();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin rem[i] = 3; nxt[i] = word(i, 0); end
        drive();
        @(posedge clk); #2;
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b expected 0000", grant_o); end
        checks++; if (fifo_wr_o !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b expected 0", fifo_wr_o); end
        checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b expected 0000", req_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        checks++; if (fifo_data_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", fifo_data_o); end
    endtask

    task automatic test_single_burst();
        int eg [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
        int ew [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        int eb [10] = '{0, 0, 1, 2, 3, 0, 4, 5, 0, 0};
        int nwr = 0;
        do_reset();
        rem[0] = 6; drive(); #1;
        for (int t = 0; t < 10; t++) begin
            checks++; if (grant_o !== 4'(eg[t])) begin errors++; $display("FAIL single_grant[%0d]: got %b expected %b", t, grant_o, 4'(eg[t])); end
            checks++; if (fifo_wr_o !== 1'(ew[t])) begin errors++; $display("FAIL single_wr[%0d]: got %b expected %b", t, fifo_wr_o, 1'(ew[t])); end
            if (ew[t] == 1) begin
                checks++; if (fifo_data_o !== word(0, eb[t])) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", t, fifo_data_o, word(0, eb[t])); end
            end
            if (eg[t] == 0) begin
                checks++; if (fifo_data_o !== 32'h0) begin errors++; $display("FAIL single_idle_data[%0d]: got %h expected 0", t, fifo_data_o); end
            end
            if (fifo_wr_o) nwr++;
            cyc();
        end
        checks++; if (nwr != 6) begin errors++; $display("FAIL single_count: got %0d expected 6", nwr); end
    endtask

    task automatic test_round_robin();
        int p, blk, g;
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = 20;
        drive(); #1;
        for (int t = 0; t < 25; t++) begin
            p = (t - 1) % 5; blk = (t - 1) / 5; g = blk % 4;
            if (t == 0 || p == 4) begin
                checks++; if (grant_o !== 4'b0000 || fifo_wr_o !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d]: got grant %b wr %b expected 0000/0", t, grant_o, fifo_wr_o); end
            end else begin
                checks++; if (grant_o !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, grant_o, 4'(1 << g)); end
                checks++; if (fifo_wr_o !== 1'b1 || fifo_data_o !== word(g, (blk / 4) * 4 + p)) begin errors++; $display("FAIL rr_data[%0d]: got wr %b data %h expected 1 %h", t, fifo_wr_o, fifo_data_o, word(g, (blk / 4) * 4 + p)); end
            end
            cyc();
        end
    endtask

    task automatic test_fifo_full();
        int nwr = 0;
        do_reset();
        rem[2] = 4; drive(); #1;
        for (int t = 0; t < 11; t++) begin
            if (t == 0 || t == 10) begin
                checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL full_idle_grant[%0d]: got %b expected 0000", t, grant_o); end
            end else if (t >= 2 && t <= 6) begin
                checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL full_hold_grant[%0d]: got %b expected 0100", t, grant_o); end
                checks++; if (fifo_wr_o !== 1'b0 || req_ready_o !== 4'b0000) begin errors++; $display("FAIL full_stall[%0d]: got wr %b ready %b expected 0 0000", t, fifo_wr_o, req_ready_o); end
            end else begin
                checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL full_ready[%0d]: got %b expected 0100", t, req_ready_o); end
                checks++; if (fifo_wr_o !== 1'b1 || fifo_data_o !== word(2, t == 1 ? 0 : t - 6)) begin errors++; $display("FAIL full_data[%0d]: got wr %b data %h expected 1 %h", t, fifo_wr_o, fifo_data_o, word(2, t == 1 ? 0 : t - 6)); end
            end
            if (fifo_wr_o) nwr++;
            full_v = (t + 1 >= 2 && t + 1 <= 6);
            cyc();
        end
        checks++; if (nwr != 4) begin errors++; $display("FAIL full_count: got %0d expected 4", nwr); end
    endtask

    task automatic test_early_drop();
        int nwr = 0;
        do_reset();
        rem[1] = 2; drive(); #1;
        for (int t = 0; t < 3; t++) begin
            if (fifo_wr_o) nwr++;
            if (t > 0) begin
                checks++; if (grant_o !== 4'b0010 || fifo_data_o !== word(1, t - 1)) begin errors++; $display("FAIL drop_beat[%0d]: got grant %b data %h expected 0010 %h", t, grant_o, fifo_data_o, word(1, t - 1)); end
            end
            if (t == 2) begin rem[0] = 5; rem[2] = 5; end
            cyc();
        end
        checks++; if (fifo_wr_o !== 1'b0 || grant_o !== 4'b0010) begin errors++; $display("FAIL drop_nowr: got wr %b grant %b expected 0 0010", fifo_wr_o, grant_o); end
        cyc();
        checks++; if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin errors++; $display("FAIL drop_idle: got busy %b grant %b expected 0 0000", busy_o, grant_o); end
        cyc();
        checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL drop_next_scan: got %b expected 0100", grant_o); end
        checks++; if (nwr != 2) begin errors++; $display("FAIL drop_count: got %0d expected 2", nwr); end
    endtask

    task automatic test_enable();
        int nwr = 0;
        do_reset();
        en_v = 1'b0; rem[3] = 10; drive(); #1;
        for (int t = 0; t < 4; t++) begin
            checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin errors++; $display("FAIL en_off[%0d]: got grant %b busy %b expected 0000 0", t, grant_o, busy_o); end
            cyc();
        end
        en_v = 1'b1; drive(); #1;
        cyc();
        for (int t = 0; t < 8; t++) begin
            if (t == 1) begin en_v = 1'b0; drive(); #1; end
            if (fifo_wr_o) nwr++;
            if (t < 4) begin
                checks++; if (grant_o !== 4'b1000 || fifo_data_o !== word(3, t)) begin errors++; $display("FAIL en_burst[%0d]: got grant %b data %h expected 1000 %h", t, grant_o, fifo_data_o, word(3, t)); end
            end else begin
                checks++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin errors++; $display("FAIL en_after[%0d]: got grant %b busy %b expected 0000 0", t, grant_o, busy_o); end
            end
            cyc();
        end
        checks++; if (nwr != 4) begin errors++; $display("FAIL en_count: got %0d expected 4", nwr); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        rem[2] = 6; drive(); #1;
        cyc(); cyc();
        checks++; if (grant_o !== 4'b0100 || fifo_data_o !== word(2, 1)) begin errors++; $display("FAIL mid_beat2: got grant %b data %h expected 0100 %h", grant_o, fifo_data_o, word(2, 1)); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (grant_o !== 4'b0000 || fifo_wr_o !== 1'b0 || req_ready_o !== 4'b0000) begin errors++; $display("FAIL mid_async: got grant %b wr %b ready %b expected 0000 0 0000", grant_o, fifo_wr_o, req_ready_o); end
        @(posedge clk); #1;
        rem[2] = 0; rem[0] = 4; rem[3] = 4; drive();
        reset_n = 1'b1; #1;
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL mid_idle: got %b expected 0000", grant_o); end
        cyc();
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b expected 0001", grant_o); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_fifo_full();
        test_early_drop();
        test_enable();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO among NUM_REQ requesters in the FIFO write-clock domain.
- Grants one requester at a time for a burst of up to MAX_BURST beats.
- Obeys the FIFO full flag and muxes the granted requester's data onto the FIFO write port.
- Sits between the matrix-multiplier result producers and the async FIFO write side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, FIFO word width.
- MAX_BURST, 4, maximum beats per grant (1..16).

Ports:
- clk  in  1  write-domain clock.
- reset_n  in  1  asynchronous active-low reset.
- enable_i  in  1  when low, no new grants issue; a burst in progress completes.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  out  NUM_REQ  per-requester ready.
- fifo_full_i  in  1  FIFO full flag (write domain).
- fifo_wr_o  out  1  FIFO write enable.
- fifo_data_o  out  DATA_WIDTH  FIFO write data.
- grant_o  out  NUM_REQ  one-hot current grant (registered).
- busy_o  out  1  high while in GRANT.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, grant_o=0, beat_cnt=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), busy_o=0. fifo_wr_o=0 and req_ready_o=0 because both are derived from grant_o.
- Reset mid-burst: the burst is abandoned. Nothing is written after reset_n falls.
- Handshake: valid/ready. A requester holds its data stable while valid is high and ready is low.
- Transfer condition for requester i: req_valid_i[i] & req_ready_o[i].
- req_ready_o[i] = (state==GRANT) & grant_o[i] & ~fifo_full_i. This path is combinational.
- Write port: fifo_wr_o = OR over i of the transfer condition. fifo_data_o = granted requester's data slice, or 0 when there is no grant. Zero latency from transfer to FIFO write.
- FSM state IDLE:
  - If enable_i and any req_valid_i, scan for the first valid requester starting at (last_grant+1) mod NUM_REQ, wrapping.
  - Register the winner into grant_o and last_grant. Clear beat_cnt. Go to GRANT.
  - Arbitration costs exactly 1 cycle. There is no transfer in the IDLE cycle.
- FSM state GRANT, evaluated in priority order:
  - Transfer and beat_cnt==MAX_BURST-1: go to IDLE, clear grant_o.
  - Else transfer: beat_cnt+1, stay in GRANT.
  - Else req_valid_i of the granted requester low: go to IDLE, clear grant_o. The burst ends early.
  - Else (FIFO full or waiting): stay in GRANT. beat_cnt is unchanged.
- enable_i has no effect in GRANT.
- Full: while fifo_full_i=1, ready=0 and wr=0. The grant is held indefinitely; there is no timeout.
- Fairness: after a grant, the granted requester has lowest priority in the next arbitration. Every continuously requesting requester is granted within NUM_REQ arbitrations.
- Simultaneous events:
  - The granted requester's last beat and new requests from others in the same cycle: IDLE next cycle, then arbitration.
  - Requests are never granted back-to-back without an IDLE cycle.
- beat_cnt width: $clog2(MAX_BURST) bits, minimum 1. It never exceeds MAX_BURST-1.
- grant_o is always one-hot or zero.

Test Plan:
- Reset, then requester 0 valid with 6 words D0..D5 and fifo_full_i=0 -> grant_o=0001 one cycle after valid. D0..D3 are written on 4 consecutive cycles. IDLE for 1 cycle. Regrant to requester 0, then D4, D5 are written. Exactly 6 fifo_wr_o pulses.
- All 4 requesters continuously valid, MAX_BURST=4 -> grant order 0,1,2,3,0. Each grant gives 4 writes, separated by one IDLE cycle. Data slices match the granted requester.
- Requester 2 granted, fifo_full_i=1 for 5 cycles after beat 1 -> ready and fifo_wr_o are 0 for those 5 cycles. grant_o stays 0100. Beats 2..4 then resume, with no loss or duplication.
- Requester 1 granted, drops valid after 2 beats -> IDLE next cycle. Only 2 writes occur. Next arbitration starts its scan at requester 2.
- enable_i=0 with requests pending -> no grant and busy_o=0. Dropping enable_i mid-burst lets the burst complete all MAX_BURST beats, with no new grant afterwards.
- reset_n asserted mid-burst (beat 2) -> grant_o=0, fifo_wr_o=0 and req_ready_o=0 immediately, without waiting for a clock edge. After release, the first grant goes to requester 0.
